fetch_unit: RTL

Instruction fetch stage that sits directly upstream of the IF_ID pipeline register. It generates the fetch PC and runs a single-outstanding request/ready handshake with instruction memory. Fetched words go into a 2-entry buffer that absorbs pipeline stalls. The unit predecodes PC-relative jumps and redirects on branch resolution from EX; it presents instruction, PC+1 and the jump flag to IF_ID, and presents NOP (16'h0000) whenever no instruction is available.

---
 rtl/fetch_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// fetch_unit: fetch PC generator with a single-outstanding imem handshake
// and a 2-entry buffer feeding IF_ID, with PC-relative jump predecode.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  JUMP_OP  = 4'hc
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_PC,
  output logic        imem_re,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic [15:0] instr_out,
  output logic [15:0] PC_out,
  output logic        jump_out
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc1;
    logic        jump;
  } fetch_ent_t;

  logic [0:0]  r_state;
  logic [15:0] r_fpc;
  logic [15:0] r_req_pc;
  logic [1:0]  r_count;
  logic        r_squash;
  fetch_ent_t  r_buf [2];

  logic        w_issue;
  logic        w_push;
  logic        w_pop;
  logic        w_wr_idx;
  logic        w_head_vld;
  logic [15:0] w_target;
  logic [1:0]  w_count_nxt;
  fetch_ent_t  w_new;

  always_comb begin
    w_issue = (r_state == IDLE) && (r_count != 2'd2)
           && !redirect && !rst;
    w_push = (r_state == WAIT) && imem_rdy
          && !r_squash && !redirect;
    w_pop = !stall && !redirect && (r_count != 2'd0);
    w_new.instr = imem_data;
    w_new.pc1 = r_req_pc + 16'd1;
    w_new.jump = (imem_data[15:12] == JUMP_OP);
    w_target = w_new.pc1;
    if (w_new.jump)
      w_target = w_new.pc1
               + {{4{imem_data[11]}}, imem_data[11:0]};
    // slot 1 only when an entry stays resident this cycle
    w_wr_idx = (r_count == 2'd1) && !w_pop;
    w_count_nxt = r_count + {1'b0, w_push}
                - {1'b0, w_pop};
    w_head_vld = (r_count != 2'd0) && !redirect;
  end

  assign imem_re   = w_issue;
  assign imem_addr = r_fpc;
  assign instr_out = w_head_vld ? r_buf[0].instr : 16'h0000;
  assign PC_out    = w_head_vld ? r_buf[0].pc1 : 16'h0000;
  assign jump_out  = w_head_vld && r_buf[0].jump;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_fpc    <= RESET_PC;
      r_req_pc <= RESET_PC;
      r_count  <= 2'd0;
      r_squash <= 1'b0;
      r_buf[0] <= '0;
      r_buf[1] <= '0;
    end else begin
      r_count <= redirect ? 2'd0 : w_count_nxt;
      if (w_pop)
        r_buf[0] <= r_buf[1];
      if (w_push)
        r_buf[w_wr_idx] <= w_new;
      unique case (r_state)
        IDLE: begin
          if (redirect) begin
            r_fpc <= redirect_PC;
          end else if (w_issue) begin
            r_req_pc <= r_fpc;
            r_state  <= WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            r_fpc <= redirect_PC;
            if (imem_rdy) begin
              r_state  <= IDLE;
              r_squash <= 1'b0;
            end else begin
              r_squash <= 1'b1;
            end
          end else if (imem_rdy) begin
            r_state  <= IDLE;
            r_squash <= 1'b0;
            if (!r_squash)
              r_fpc <= w_target;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
